// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for the pipeline stage buffer        |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    case (s)
      ONE:     state_occupancy = 2'd1;
      TWO:     state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_perf_cnt.sv
// +----------------------------------------------------------------------------+
// | pipe_perf_cnt : free-running wrapping event counter with enable            |
// | Rev 1.0       : initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// +----------------------------------------------------------------------------+
// | pipe_stage_buf : one pipeline stage register with valid/ready handshake,   |
// |                  2-entry skid buffer and synchronous flush.                |
// |                  Optional PIPE_STAGE_PERF_EN adds stall/bubble counters.   |
// | Rev 1.0        : initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 160,
  parameter int PC_W      = XLEN,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_wen,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_wen,
  output logic [PAYLOAD_W-1:0]  out_payload,
  output logic [1:0]            occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_bubble_cnt
`endif
);

  stage_state_t          r_state;
  logic [PC_W-1:0]       r_main_pc;
  logic [REG_ADDR_W-1:0] r_main_rd;
  logic                  r_main_wen;
  logic [PAYLOAD_W-1:0]  r_main_payload;
  logic [PC_W-1:0]       r_skid_pc;
  logic [REG_ADDR_W-1:0] r_skid_rd;
  logic                  r_skid_wen;
  logic [PAYLOAD_W-1:0]  r_skid_payload;

  logic w_in_fire;
  logic w_out_fire;

  assign in_ready   = !rst && (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Main entry fields are zeroed on every entry into EMPTY, so out_* need no gating here.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state        <= EMPTY;
      r_main_pc      <= '0;
      r_main_rd      <= '0;
      r_main_wen     <= 1'b0;
      r_main_payload <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_state        <= ONE;
            r_main_pc      <= in_pc;
            r_main_rd      <= in_rd;
            r_main_wen     <= in_reg_wen;
            r_main_payload <= in_payload;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_pc      <= in_pc;
            r_main_rd      <= in_rd;
            r_main_wen     <= in_reg_wen;
            r_main_payload <= in_payload;
          end else if (w_in_fire) begin
            r_state        <= TWO;
            r_skid_pc      <= in_pc;
            r_skid_rd      <= in_rd;
            r_skid_wen     <= in_reg_wen;
            r_skid_payload <= in_payload;
          end else if (w_out_fire) begin
            r_state        <= EMPTY;
            r_main_pc      <= '0;
            r_main_rd      <= '0;
            r_main_wen     <= 1'b0;
            r_main_payload <= '0;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_state        <= ONE;
            r_main_pc      <= r_skid_pc;
            r_main_rd      <= r_skid_rd;
            r_main_wen     <= r_skid_wen;
            r_main_payload <= r_skid_payload;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

  assign out_pc      = r_main_pc;
  assign out_rd      = r_main_rd;
  assign out_reg_wen = r_main_wen && out_valid;
  assign out_payload = r_main_payload;
  assign occupancy   = state_occupancy(r_state);

`ifdef PIPE_STAGE_PERF_EN
  logic w_stall_en;
  logic w_bubble_en;

  assign w_stall_en  = out_valid && !out_ready;
  assign w_bubble_en = !out_valid;

  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall_en),
    .o_count (perf_stall_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_bubble_en),
    .o_count (perf_bubble_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
// +----------------------------------------------------------------------------+
// | tb_pipe_stage_buf : directed self-checking bench for pipe_stage_buf        |
// | Rev 1.0           : initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_stage_buf;

  localparam int PAYLOAD_W = 160;
  localparam int PC_W      = 64;
`ifdef PIPE_STAGE_PERF_EN
  localparam int CNT_W     = 4;
`else
  localparam int CNT_W     = 32;
`endif

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_W-1:0]      in_pc;
  logic [4:0]           in_rd;
  logic                 in_reg_wen;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_W-1:0]      out_pc;
  logic [4:0]           out_rd;
  logic                 out_reg_wen;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [1:0]           occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]     perf_stall_cnt;
  logic [CNT_W-1:0]     perf_bubble_cnt;
`endif

  int assertions = 0;
  int failures   = 0;

  pipe_stage_buf #(
    .PAYLOAD_W (PAYLOAD_W),
    .PC_W      (PC_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_rd       (in_rd),
    .in_reg_wen  (in_reg_wen),
    .in_payload  (in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rd      (out_rd),
    .out_reg_wen (out_reg_wen),
    .out_payload (out_payload),
    .occupancy   (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic [4:0] rd, input logic wen);
    in_valid   = v;
    in_pc      = pc;
    in_rd      = rd;
    in_reg_wen = wen;
    in_payload = {5{pc[31:0]}};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 64'hDEAD, 5'd9, 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      assertions++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd0) begin
        failures++;
        $display("FAIL reset_ctrl cyc%0d: valid=%b ready=%b occ=%0d, want 0 0 0", c, out_valid, in_ready, occupancy);
      end
      assertions++;
      if (out_pc !== '0 || out_rd !== 5'd0 || out_reg_wen !== 1'b0 || out_payload !== '0) begin
        failures++;
        $display("FAIL reset_data cyc%0d: pc=%h rd=%0d wen=%b, want all zero", c, out_pc, out_rd, out_reg_wen);
      end
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b, want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] pcs [4] = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pcs[i], 5'(i + 1), 1'b0);
      #1;
      assertions++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d]: in_ready=%b, want 1", i, in_ready);
      end
      tick();
      assertions++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || occupancy !== 2'd1 || out_payload !== {5{pcs[i][31:0]}}) begin
        failures++;
        $display("FAIL stream_out[%0d]: valid=%b pc=%h occ=%0d, want 1 %h 1", i, out_valid, out_pc, occupancy, pcs[i]);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    assertions++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== '0) begin
      failures++;
      $display("FAIL stream_drain: valid=%b occ=%0d pc=%h, want 0 0 0", out_valid, occupancy, out_pc);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 64'h2000, 5'd1, 1'b1);
    tick();
    drive(1'b1, 64'h2004, 5'd2, 1'b1);
    tick();
    assertions++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 64'h2000) begin
      failures++;
      $display("FAIL bp_full: occ=%0d ready=%b pc=%h, want 2 0 2000", occupancy, in_ready, out_pc);
    end
    drive(1'b1, 64'h2008, 5'd3, 1'b1);
    tick();
    assertions++;
    if (occupancy !== 2'd2 || out_pc !== 64'h2000 || out_rd !== 5'd1) begin
      failures++;
      $display("FAIL bp_hold: occ=%0d pc=%h rd=%0d, want 2 2000 1", occupancy, out_pc, out_rd);
    end
    out_ready = 1'b1;
    tick();
    assertions++;
    if (out_pc !== 64'h2004 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_pop1: pc=%h occ=%0d ready=%b, want 2004 1 1", out_pc, occupancy, in_ready);
    end
    tick();
    assertions++;
    if (out_pc !== 64'h2008 || out_rd !== 5'd3 || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL bp_pop2: pc=%h rd=%0d occ=%0d, want 2008 3 1", out_pc, out_rd, occupancy);
    end
    drive(1'b0, '0, '0, 1'b0);
    tick();
    assertions++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL bp_drain: valid=%b occ=%0d, want 0 0 (duplicate entry?)", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 64'h3000, 5'd4, 1'b1);
    tick();
    drive(1'b1, 64'h3004, 5'd5, 1'b1);
    tick();
    drive(1'b1, 64'h3008, 5'd7, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    assertions++;
    if (out_valid !== 1'b0 || out_reg_wen !== 1'b0 || out_rd !== 5'd0 || occupancy !== 2'd0 || out_pc !== '0 || out_payload !== '0) begin
      failures++;
      $display("FAIL flush_full: valid=%b wen=%b rd=%0d occ=%0d pc=%h, want all zero", out_valid, out_reg_wen, out_rd, occupancy, out_pc);
    end
    tick();
    assertions++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL flush_drop: valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
    // Input offered with in_ready=1 during flush must be dropped.
    out_ready = 1'b1;
    drive(1'b1, 64'h3100, 5'd8, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    assertions++;
    if (out_valid !== 1'b0 || out_pc !== '0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL flush_ready_drop: valid=%b pc=%h occ=%0d, want 0 0 0", out_valid, out_pc, occupancy);
    end
  endtask

  task automatic test_gating();
    out_ready = 1'b1;
    drive(1'b1, 64'h4000, 5'd5, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    assertions++;
    if (out_reg_wen !== 1'b1 || out_rd !== 5'd5 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL gate_on: wen=%b rd=%0d valid=%b, want 1 5 1", out_reg_wen, out_rd, out_valid);
    end
    tick();
    assertions++;
    if (out_reg_wen !== 1'b0 || out_rd !== 5'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL gate_off: wen=%b rd=%0d valid=%b, want 0 0 0", out_reg_wen, out_rd, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 64'h5000, 5'd6, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    assertions++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_reg_wen !== 1'b0 || out_pc !== '0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b occ=%0d wen=%b pc=%h, want all zero", out_valid, occupancy, out_reg_wen, out_pc);
    end
    tick();
  endtask

`ifdef PIPE_STAGE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    drive(1'b1, 64'h6000, 5'd1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    assertions++;
    if (perf_bubble_cnt !== 4'd3 || perf_stall_cnt !== 4'd4) begin
      failures++;
      $display("FAIL perf_counts: bubble=%0d stall=%0d, want 3 4", perf_bubble_cnt, perf_stall_cnt);
    end
    for (int c = 0; c < 16; c++) tick();
    assertions++;
    if (perf_stall_cnt !== 4'd4 || perf_bubble_cnt !== 4'd3) begin
      failures++;
      $display("FAIL perf_wrap: stall=%0d bubble=%0d, want 4 3", perf_stall_cnt, perf_bubble_cnt);
    end
    out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    in_valid   = 1'b0;
    in_pc      = '0;
    in_rd      = '0;
    in_reg_wen = 1'b0;
    in_payload = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_gating();
    test_reset_mid();
`ifdef PIPE_STAGE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed EX→MEM register in the rv64 pipeline core.
- Registers one pipeline stage's bundle: PC, destination-register info and a generic payload.
- Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is driven from a register, and a synchronous flush.
- Instantiated between any two stages: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- PAYLOAD_W, 160, width of the opaque stage payload: load/store info, opcode info, operands, ALU result and commit info, concatenated by the instantiating stage.
- PC_W, 64, program-counter width.
- CNT_W, 32, width of the performance counters (only used with PIPE_STAGE_PERF_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_pc  in  PC_W  upstream PC
- in_rd  in  5  upstream destination register
- in_reg_wen  in  1  upstream register-write enable
- in_payload  in  PAYLOAD_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_pc  out  PC_W  head PC
- out_rd  out  5  head destination register
- out_reg_wen  out  1  head register-write enable, already gated by out_valid (for hazard and forwarding logic)
- out_payload  out  PAYLOAD_W  head payload
- occupancy  out  2  number of held entries (0..2)
- perf_stall_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN
- perf_bubble_cnt  out  CNT_W  only with PIPE_STAGE_PERF_EN

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high, sampled on the posedge of clk.
- Storage: main entry (drives the out_* ports) plus one skid entry.
- State encoding: EMPTY (neither valid), ONE (main valid), TWO (main and skid valid).
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !rst & (state != TWO), a function of registered state only.
  - out_valid = (state != EMPTY).
- Transitions (on posedge, when no rst and no flush):
  - EMPTY: in_fire → main<=in, go to ONE.
  - ONE: in_fire & out_fire → main<=in, stay ONE. in_fire only → skid<=in, go to TWO. out_fire only → EMPTY. Neither → hold.
  - TWO: out_fire → main<=skid, go to ONE. The input cannot fire in TWO.
- Ordering is strictly FIFO. Latency is 1 cycle from in_fire to out_valid when the stage was EMPTY, or when ONE with a simultaneous out_fire.
- Entry-field rule: fields of a non-valid entry are don't-care internally, but out_rd, out_pc and out_payload are zeroed whenever the stage enters EMPTY. out_reg_wen is 0 when out_valid is 0.
- Flush:
  - Next state is EMPTY and all out_* ports are zeroed.
  - An input presented in the flush cycle is dropped even if in_ready=1.
  - An out_fire in the flush cycle is still a completed transfer (downstream has taken it).
- Priority: rst > flush > normal operation.
- Reset:
  - state=EMPTY; out_valid, out_pc, out_rd, out_reg_wen, out_payload and occupancy all 0.
  - in_ready is 0 during the reset cycle and 1 on the cycle after.
  - Reset mid-transfer discards both entries.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in TWO.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_bubble_cnt increments each cycle with !out_valid.
  - Both wrap modulo 2^CNT_W. Both are cleared by rst but not by flush.
- Undefined: the perf ports and counter logic are absent.

Decomposition:
- Shared package pipe_pkg holds:
  - The state enum (EMPTY/ONE/TWO).
  - The constants XLEN=64 and REG_ADDR_W=5.
- Natural sub-module: pipe_perf_cnt (a single saturation-free wrapping counter with an enable input), instantiated twice under the macro.
- The core stage logic stays flat.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 → out_valid=0, all outputs 0 and occupancy=0 throughout; in_ready goes 1 on the first cycle after rst drops.
- Streaming: out_ready=1 and 4 back-to-back inputs with PC 0x1000, 0x1004, 0x1008, 0x100C → the same PCs appear in order, each 1 cycle later; occupancy stays 1 and in_ready never drops.
- Backpressure: out_ready=0 while PC 0x2000, then 0x2004, are sent → occupancy=2 and in_ready=0; a third input (0x2008) is held upstream. Raising out_ready delivers 0x2000, 0x2004, 0x2008 in order with nothing lost or duplicated.
- Flush: with occupancy=2 and in_valid=1, pulse flush → next cycle out_valid=0, out_reg_wen=0, out_rd=0 and occupancy=0; the flushed-cycle input never appears.
- Gating: input rd=5, reg_wen=1 followed by an idle cycle → out_reg_wen=1 with out_rd=5 for one cycle, then out_reg_wen=0 and out_rd=0 once EMPTY.
- With PIPE_STAGE_PERF_EN, after reset: 3 idle cycles, then 1 input held for 4 cycles with out_ready=0 → perf_bubble_cnt=3 and perf_stall_cnt=4. Set CNT_W=4 and run 16 more stall cycles → perf_stall_cnt wraps back to 4.
